// File: rtl/dac_slew_feeder.sv
// Sample-strobe generator and slew-limited data driver for the sigma-delta DAC stage.
// Data steps toward a loaded target by at most `step` per strobe, so setpoint changes never jump.
module dac_slew_feeder #(
  parameter int WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 load,
  input  logic [WIDTH-1:0]     target_in,
  input  logic [WIDTH-1:0]     step_in,
  output logic [WIDTH-1:0]     data,
  output logic                 ena,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     target;
  logic [WIDTH-1:0]     step;
  logic                 tick;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       mag;
  logic                 reach;

  assign tick = (cnt == '0);

  // diff is two's complement in WIDTH+1 bits; its top bit is the direction of travel.
  always_comb begin
    diff  = {1'b0, target} - {1'b0, data};
    mag   = diff[WIDTH] ? (~diff + 1'b1) : diff;
    reach = (step == '0) || (mag <= {1'b0, step});
  end

  // busy is the registered image of state == RAMP and serves as the state observation point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ena    <= 1'b0;
      data   <= INIT_VALUE;
      target <= INIT_VALUE;
      step   <= '0;
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ena  <= tick;
      done <= 1'b0;
      cnt  <= tick ? div : cnt - 1'b1;

      if (tick && state == RAMP) begin
        if (reach) begin
          data  <= target;
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (!diff[WIDTH]) begin
          data <= data + step;
        end else begin
          data <= data - step;
        end
      end

      // A load on a tick lets the tick finish with the old values and defers completion to the next tick.
      if (load) begin
        target <= target_in;
        step   <= step_in;
        if (tick) begin
          state <= RAMP;
          busy  <= 1'b1;
          done  <= 1'b0;
        end else if (target_in != data) begin
          state <= RAMP;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_slew_feeder.sv
// Bench for dac_slew_feeder: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a cycle-level arithmetic model.
module tb_dac_slew_feeder;

  localparam int WIDTH = 8;
  localparam int DIV_WIDTH = 16;
  localparam logic [WIDTH-1:0] INIT_VALUE = 8'd0;

  logic                 clk;
  logic                 rst;
  logic [DIV_WIDTH-1:0] div;
  logic                 load;
  logic [WIDTH-1:0]     target_in;
  logic [WIDTH-1:0]     step_in;
  logic [WIDTH-1:0]     data;
  logic                 ena;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {busy, done, ena, data}.
  logic [WIDTH+2:0] exp_q[$];

  dac_slew_feeder #(
    .WIDTH(WIDTH),
    .DIV_WIDTH(DIV_WIDTH),
    .INIT_VALUE(INIT_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .div(div),
    .load(load),
    .target_in(target_in),
    .step_in(step_in),
    .data(data),
    .ena(ena),
    .busy(busy),
    .done(done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ed, input logic ee,
                            input logic eb, input logic edn);
    check({tag, " data"}, 32'(data), 32'(ed));
    check({tag, " ena"},  32'(ena),  32'(ee));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " done"}, 32'(done), 32'(edn));
  endtask

  // Drivers: called at time 0 or 1 time unit after a rising edge; return 1 unit after the next edge.
  task automatic do_reset(input logic [DIV_WIDTH-1:0] dv);
    div       = dv;
    load      = 1'b0;
    target_in = '0;
    step_in   = '0;
    rst       = 1'b1;
    #1;
    expect_out("reset", INIT_VALUE, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply(input logic [DIV_WIDTH-1:0] dv, input logic ld,
                       input logic [7:0] t, input logic [7:0] s);
    div       = dv;
    load      = ld;
    target_in = t;
    step_in   = s;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Reference model: strobe times as absolute edge numbers, ramp as integer arithmetic.
  int m_edge, m_next, m_data, m_target, m_step;
  bit m_ramp;

  task automatic model_reset();
    m_edge   = 0;
    m_next   = 0;
    m_data   = int'(INIT_VALUE);
    m_target = int'(INIT_VALUE);
    m_step   = 0;
    m_ramp   = 0;
  endtask

  task automatic model_edge(input int dv, input bit ld, input int tin, input int sin);
    bit tk;
    bit dn;
    int d;
    int ad;
    logic [7:0] d8;
    tk = (m_edge == m_next);
    dn = 0;
    if (tk) m_next = m_edge + dv + 1;
    if (tk && m_ramp) begin
      d  = m_target - m_data;
      ad = (d < 0) ? -d : d;
      if (m_step == 0 || ad <= m_step) begin
        m_data = m_target;
        m_ramp = 0;
        dn     = 1;
      end else begin
        m_data = m_data + ((d > 0) ? m_step : -m_step);
      end
    end
    if (ld) begin
      if (tk) begin
        m_ramp = 1;
        dn     = 0;
      end else begin
        m_ramp = (tin != m_data);
        dn     = !m_ramp;
      end
      m_target = tin;
      m_step   = sin;
    end
    m_edge++;
    d8 = m_data[7:0];
    exp_q.push_back({m_ramp, dn, tk, d8});
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] tin;
    logic [7:0] sin;
    logic [7:0] ed;
    logic       ee;
    logic       eb;
    logic       edn;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [WIDTH+2:0] e;
    int dv;
    int tin;
    int sin;
    bit ld;

    // Directed table: div=0 so every edge is a strobe.
    tbl[0]  = '{1'b0, 8'd0,   8'd0,  8'd0,   1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'd200, 8'd50, 8'd0,   1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'd0,   8'd0,  8'd50,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'd0,   8'd0,  8'd100, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'd0,   8'd0,  8'd150, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'd0,   8'd0,  8'd200, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'd0,   8'd0,  8'd200, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'd10,  8'd64, 8'd200, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'd0,   8'd0,  8'd136, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'd0,   8'd0,  8'd72,  1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0,   8'd0,  8'd10,  1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'd0,   8'd0,  8'd10,  1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'd250, 8'd20, 8'd10,  1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'd0,   8'd0,  8'd30,  1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'd100, 8'd20, 8'd50,  1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'd0,   8'd0,  8'd70,  1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'd0,   8'd0,  8'd90,  1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'd0,   8'd0,  8'd100, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 8'd0,   8'd0,  8'd100, 1'b1, 1'b0, 1'b0};

    // Prescaler alone, div=3
    do_reset(16'd3);
    for (int i = 0; i < 12; i++) begin
      apply(16'd3, 1'b0, 8'd0, 8'd0);
      expect_out($sformatf("presc[%0d]", i), INIT_VALUE, (i % 4) == 0, 1'b0, 1'b0);
    end

    do_reset(16'd0);
    for (int i = 0; i < 19; i++) begin
      apply(16'd0, tbl[i].ld, tbl[i].tin, tbl[i].sin);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].ed, tbl[i].ee, tbl[i].eb, tbl[i].edn);
    end

    // Unlimited step with div=9, then equal-target load, then async reset mid-ramp.
    do_reset(16'd9);
    apply(16'd9, 1'b0, 8'd0, 8'd0);
    expect_out("s0 e0", 8'd0, 1'b1, 1'b0, 1'b0);
    apply(16'd9, 1'b1, 8'd255, 8'd0);
    expect_out("s0 load", 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i < 10; i++) begin
      apply(16'd9, 1'b0, 8'd0, 8'd0);
      expect_out($sformatf("s0 wait%0d", i), 8'd0, 1'b0, 1'b1, 1'b0);
    end
    apply(16'd9, 1'b0, 8'd0, 8'd0);
    expect_out("s0 jump", 8'd255, 1'b1, 1'b0, 1'b1);
    apply(16'd9, 1'b1, 8'd255, 8'd7);
    expect_out("eq load", 8'd255, 1'b0, 1'b0, 1'b1);
    apply(16'd9, 1'b1, 8'd0, 8'd1);
    expect_out("down load", 8'd255, 1'b0, 1'b1, 1'b0);
    for (int i = 13; i < 20; i++) begin
      apply(16'd9, 1'b0, 8'd0, 8'd0);
      expect_out($sformatf("down wait%0d", i), 8'd255, 1'b0, 1'b1, 1'b0);
    end
    apply(16'd9, 1'b0, 8'd0, 8'd0);
    expect_out("down step", 8'd254, 1'b1, 1'b1, 1'b0);
    do_reset(16'd2);

    // Randomized traffic against the model
    model_reset();
    dv = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) dv = $urandom_range(0, 4);
      ld = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       tin = m_data;
        1:       tin = 0;
        2:       tin = 255;
        default: tin = $urandom_range(0, 255);
      endcase
      sin = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255);
      if ($urandom_range(0, 3) == 0) sin = $urandom_range(1, 8);
      if ($urandom_range(0, 299) == 0) begin
        exp_q.delete();
        do_reset(16'(dv));
        model_reset();
      end else begin
        model_edge(dv, ld, tin, sin);
        apply(16'(dv), ld, 8'(tin), 8'(sin));
        e = exp_q.pop_front();
        expect_out($sformatf("rnd[%0d]", i), e[7:0], e[8], e[10], e[9]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_slew_feeder.md
Name: dac_slew_feeder

Overview:
Upstream feeder for the first-order sigma-delta DAC stage. It generates that stage's sample-enable strobe from a programmable prescaler. It also drives the stage's data word, moving it toward a software-loaded target at a bounded rate per strobe. This keeps the filtered analog output free of steps when the setpoint changes.

Parameters:
WIDTH, 8, width of target, step and data words (must match the DAC stage's WIDTH).
DIV_WIDTH, 16, width of the prescaler divisor.
INIT_VALUE, 0, value of data after reset (WIDTH bits).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
div  input  DIV_WIDTH  strobe period minus one, in clk cycles
load  input  1  single-cycle request to latch target_in/step_in
target_in  input  WIDTH  new setpoint
step_in  input  WIDTH  maximum change of data per strobe; 0 = unlimited
data  output  WIDTH  word to DAC stage
ena  output  1  sample strobe to DAC stage
busy  output  1  high while data != latched target (RAMP state)
done  output  1  one-cycle pulse when data reaches target

Behaviour:
- Reset (async, active-high): cnt=0, ena=0, data=INIT_VALUE, target=INIT_VALUE, step=0, state=IDLE, busy=0, done=0.
- Prescaler:
  - Internal tick = (cnt==0). On tick, cnt<=div; otherwise cnt<=cnt-1.
  - ena is registered: ena<=tick. The strobe period is div+1 cycles; div=0 gives ena high every cycle.
  - A change of div takes effect at the next reload only.
  - The first ena occurs at the first clk edge after rst deasserts.
- Data and ena are registered on the same edge. The DAC stage therefore samples the updated data in the cycle ena is high.
- States: IDLE, RAMP.
- load, in any state, latches target<=target_in and step<=step_in.
  - If target_in != current data: state<=RAMP.
  - Else: state<=IDLE and done pulses the next cycle.
- On tick in RAMP, with diff=target-data computed in WIDTH+1 signed bits:
  - If step==0 or |diff|<=step: data<=target, state<=IDLE, done<=1 for one cycle.
  - Else if diff>0: data<=data+step. Else: data<=data-step.
  - Never wraps; overshoot is impossible by the |diff| rule.
- A tick in IDLE leaves data unchanged. ena still pulses so the DAC keeps modulating.
- load coincident with tick:
  - The tick is processed with the old target/step.
  - The new values are latched and done is suppressed.
  - state<=RAMP; the next tick re-evaluates, completing immediately with done if data already equals the new target.
- busy = (state==RAMP), registered.
- rst asserted mid-ramp: immediate return to reset values; the pending target is discarded.
- Full-scale moves: 0->2^WIDTH-1 and the reverse complete without arithmetic overflow.

Test Plan:
1. rst pulse, div=3, no load -> ena high one cycle every 4 clks, first at the first edge after reset; data=INIT_VALUE; busy=0.
2. div=0, load target=200 step=50 from data=0 -> data 50,100,150,200 on consecutive ena; done pulses with the 200 update; busy falls the same edge.
3. data=200, load target=10 step=64 -> data 136,72,10; the final step is clipped to 10, with no underflow or wrap.
4. step=0, load target=255 from data=0, div=9 -> data=255 at the next ena; done one cycle.
5. Mid-ramp load target=100 on the same cycle as tick -> that tick uses the old target; done is not pulsed; later ticks ramp toward 100.
6. load target equal to current data in IDLE -> done pulses next cycle, busy stays 0; async rst mid-ramp -> data=INIT_VALUE immediately, without waiting for a clk edge.
